// File: rtl/shift_pkg.sv
// Shared shifter definitions: default geometry, sequencer state encoding and
// the ALU shift-op control codes used by both the left and right shifters.
package shift_pkg;

    localparam int DEFAULT_WIDTH   = 32;
    localparam int DEFAULT_SHAMT_W = 5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // ALU op-decode encodings for the shift family
    typedef enum logic [1:0] {
        ALU_SLL = 2'b00,
        ALU_SRL = 2'b01,
        ALU_SRA = 2'b10
    } shift_ctrl_t;

endpackage : shift_pkg

// File: rtl/shift_stage_r.sv
// One combinational right-shift stage: shifts by 2^k when enabled, filling
// the vacated MSBs with the fill bit; otherwise passes the data through.
module shift_stage_r #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5,
    parameter int K_W     = 3
) (
    input  logic [WIDTH-1:0] i_data,
    input  logic [K_W-1:0]   i_k,
    input  logic             i_en,
    input  logic             i_fill,
    output logic [WIDTH-1:0] o_data
);

    logic [WIDTH-1:0] w_cand [SHAMT_W];

    for (genvar s = 0; s < SHAMT_W; s++) begin : g_cand
        localparam int N = 2 ** s;
        assign w_cand[s] = {{N{i_fill}}, i_data[WIDTH-1:N]};
    end

    always_comb begin
        o_data = i_data;
        if (i_en) begin
            for (int s = 0; s < SHAMT_W; s++) begin
                if (i_k == K_W'(s)) begin
                    o_data = w_cand[s];
                end
            end
        end
    end

endmodule : shift_stage_r

// File: rtl/right_shift_seq.sv
// Iterative right shifter: one binary-weighted stage per clock, lowest first.
// Define ARSHIFT_EN to let `arith` select sign fill; otherwise fill is always 0.
module right_shift_seq
    import shift_pkg::*;
#(
    parameter int WIDTH   = DEFAULT_WIDTH,
    parameter int SHAMT_W = DEFAULT_SHAMT_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   a,
    input  logic [SHAMT_W-1:0] b,
    input  logic               arith,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out,
    output state_t             dbg_state
);

    localparam int K_W = (SHAMT_W > 1) ? $clog2(SHAMT_W) : 1;
    localparam logic [K_W-1:0] LAST_K = K_W'(SHAMT_W - 1);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [WIDTH-1:0]   r_data;
    logic [SHAMT_W-1:0] r_amt;
    logic               r_fill;
    logic [K_W-1:0]     r_k;
    logic [WIDTH-1:0]   r_out;
    logic               r_out_valid;

    logic               w_accept;
    logic               w_last;
    logic               w_fill_in;
    logic [WIDTH-1:0]   w_stage;

`ifdef ARSHIFT_EN
    assign w_fill_in = arith & a[WIDTH-1];
`else
    logic w_unused_arith;
    assign w_unused_arith = arith;
    assign w_fill_in      = 1'b0;
`endif

    // Handshake: a transfer happens on a rising edge where valid && ready.
    // in_ready is also high in DONE when the result is being taken this
    // cycle, so release and the next capture can share one edge.
    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        w_last      = 1'b0;
        case (r_state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) w_state_nxt = SHIFT;
            end
            SHIFT: begin
                if (r_k == LAST_K) begin
                    w_last      = 1'b1;
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    in_ready    = 1'b1;
                    w_state_nxt = in_valid ? SHIFT : IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    assign w_accept = in_valid && in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_state_nxt;
    end

    shift_stage_r #(
        .WIDTH   (WIDTH),
        .SHAMT_W (SHAMT_W),
        .K_W     (K_W)
    ) u_stage (
        .i_data (r_data),
        .i_k    (r_k),
        .i_en   (r_amt[r_k]),
        .i_fill (r_fill),
        .o_data (w_stage)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data <= '0;
            r_amt  <= '0;
            r_fill <= 1'b0;
            r_k    <= '0;
        end else if (w_accept) begin
            r_data <= a;
            r_amt  <= b;
            r_fill <= w_fill_in;
            r_k    <= '0;
        end else if (r_state == SHIFT) begin
            r_data <= w_stage;
            r_k    <= r_k + 1'b1;
        end
    end

    // The result register only loads from the final stage, so a partial
    // value can never be presented with out_valid high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out       <= '0;
            r_out_valid <= 1'b0;
        end else if (w_last) begin
            r_out       <= w_stage;
            r_out_valid <= 1'b1;
        end else if (r_state == DONE && out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign out       = r_out;
    assign out_valid = r_out_valid;
    assign dbg_state = r_state;

endmodule : right_shift_seq
